// File: rtl/systolic_arbiter.sv
// systolic_arbiter: round-robin arbiter and sequencer sharing one 4x4 systolic core between requesters
//   clk_i, reset_i        clock, synchronous active-low reset
//   req_valid_i/ready_o   per-requester operand beats, req_data_i slice i = requester i
//   rsp_valid_o/ready_i   per-requester result beats on shared rsp_data_o, rsp_err_o flags an aborted job
//   core_*                job start strobe, operand stream out, result stream in, completion pulse
//   busy_o, grant_id_o    core ownership and current owner index
module systolic_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IN_BEATS  = 4,
    parameter int OUT_BEATS = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [64*NUM_REQ-1:0]      req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    output logic [63:0]                rsp_data_o,
    input  logic [NUM_REQ-1:0]         rsp_ready_i,
    output logic                       rsp_err_o,
    output logic                       core_valid_in_o,
    output logic                       core_in_valid_o,
    output logic [63:0]                core_in_data_o,
    input  logic                       core_in_ready_i,
    input  logic                       core_out_valid_i,
    input  logic [63:0]                core_out_data_i,
    output logic                       core_out_ready_o,
    input  logic                       core_done_i,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int IW = $clog2(IN_BEATS + 1);
    localparam int OW = $clog2(OUT_BEATS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, SEND, WAIT, RECV, ABORT, RELEASE} state_t;

    state_t          state_q;
    logic [GW-1:0]   rr_q, grant_q, grant_d, idx;
    logic [IW-1:0]   in_cnt_q;
    logic [OW-1:0]   out_cnt_q;
    logic [TW-1:0]   wdog_q;
    logic            done_q, busy_q, hit;
    logic [63:0]     beat [NUM_REQ];
    logic [NUM_REQ-1:0] sel;
    logic            send, recv_on, abort, in_xfer, out_xfer, done_seen;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_beat
        assign beat[g] = req_data_i[64*g +: 64];
    end

    // Descending scan so the lowest offset from rr_q is the last (winning) assignment.
    always_comb begin
        grant_d = rr_q;
        hit     = 1'b0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = GW'((int'(rr_q) + k) % NUM_REQ);
            if (req_valid_i[idx]) begin
                grant_d = idx;
                hit     = 1'b1;
            end
        end
    end

    // recv_on drops once every result beat is taken; RECV then only waits for core_done.
    assign sel       = NUM_REQ'(1) << grant_q;
    assign send      = state_q == SEND;
    assign recv_on   = state_q == RECV && out_cnt_q != OW'(OUT_BEATS);
    assign abort     = state_q == ABORT;
    assign in_xfer   = send && req_valid_i[grant_q] && core_in_ready_i;
    assign out_xfer  = recv_on && core_out_valid_i && rsp_ready_i[grant_q];
    assign done_seen = done_q || core_done_i;

    assign req_ready_o      = send && core_in_ready_i ? sel : '0;
    assign rsp_valid_o      = (recv_on && core_out_valid_i) || abort ? sel : '0;
    assign rsp_data_o       = recv_on ? core_out_data_i : '0;
    assign rsp_err_o        = abort;
    assign core_valid_in_o  = state_q == START;
    assign core_in_valid_o  = send && req_valid_i[grant_q];
    assign core_in_data_o   = send ? beat[grant_q] : '0;
    assign core_out_ready_o = recv_on && rsp_ready_i[grant_q];
    assign busy_o           = busy_q;
    assign grant_id_o       = grant_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wdog_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (hit) begin
                    grant_q <= grant_d;
                    busy_q  <= 1'b1;
                    state_q <= START;
                end
                START: state_q <= SEND;
                SEND: if (in_xfer) begin
                    in_cnt_q <= in_cnt_q + 1'b1;
                    if (in_cnt_q == IW'(IN_BEATS - 1)) begin
                        wdog_q  <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    done_q <= done_seen;
                    wdog_q <= wdog_q + 1'b1;
                    if (core_out_valid_i) state_q <= RECV;
                    else if (wdog_q == TW'(TIMEOUT - 1)) state_q <= ABORT;
                end
                RECV: begin
                    done_q <= done_seen;
                    if (out_xfer) out_cnt_q <= out_cnt_q + 1'b1;
                    if (((out_xfer && out_cnt_q == OW'(OUT_BEATS - 1)) || !recv_on) && done_seen)
                        state_q <= RELEASE;
                end
                ABORT: if (rsp_ready_i[grant_q]) state_q <= RELEASE;
                RELEASE: begin
                    rr_q      <= grant_q == GW'(NUM_REQ - 1) ? '0 : grant_q + 1'b1;
                    in_cnt_q  <= '0;
                    out_cnt_q <= '0;
                    wdog_q    <= '0;
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
